// File: rtl/jeff_74x157_scanner.sv
// jeff_74x157_scanner: alternately selects mux channels A/B, captures y after a dwell, reports pairs
module jeff_74x157_scanner #(
    parameter int WIDTH = 4,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             stop,
    input  logic [WIDTH-1:0] y,
    output logic             s,
    output logic             en,
    output logic [WIDTH-1:0] a_data,
    output logic [WIDTH-1:0] b_data,
    output logic             pair_valid,
    output logic             busy,
    output logic [7:0]       scan_count
);
    typedef enum logic [1:0] {IDLE, SEL_A, SEL_B} state_t;
    localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          cont_q;
    logic          stop_req;
    logic          last;
    assign last = cnt == CW'(DWELL - 1);
    // scan FSM; s/en/busy are registered alongside the state so outputs never glitch from inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            cont_q     <= 1'b0;
            stop_req   <= 1'b0;
            s          <= 1'b0;
            en         <= 1'b0;
            busy       <= 1'b0;
            pair_valid <= 1'b0;
            a_data     <= '0;
            b_data     <= '0;
            scan_count <= '0;
        end else begin
            pair_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= SEL_A;
                    s        <= 1'b0;
                    en       <= 1'b1;
                    busy     <= 1'b1;
                    cont_q   <= cont;
                    stop_req <= 1'b0;
                    cnt      <= '0;
                end
                SEL_A: begin
                    if (stop) stop_req <= 1'b1;
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        a_data <= y;
                        state  <= SEL_B;
                        s      <= 1'b1;
                    end
                end
                SEL_B: begin
                    if (stop) stop_req <= 1'b1;
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        b_data     <= y;
                        pair_valid <= 1'b1;
                        scan_count <= scan_count + 8'd1;
                        s          <= 1'b0;
                        if (cont_q && !stop_req && !stop) begin
                            state <= SEL_A;
                        end else begin
                            state <= IDLE;
                            en    <= 1'b0;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    en    <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jeff_74x157_scanner.sv
// tb_jeff_74x157_scanner: scoreboard bench with a behavioural 74x157 mux in the feedback loop
module tb_jeff_74x157_scanner;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] a_in = 4'h0;
    logic [3:0] b_in = 4'h0;
    logic [3:0] y;
    logic       s, en, pair_valid, busy;
    logic [3:0] a_data, b_data;
    logic [7:0] scan_count;
    int         cyc = 0;
    int         vectors = 0;
    int         fails = 0;
    int         k;
    int         n = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] cnt;
        int         c;
    } exp_t;
    exp_t q[$];
    exp_t e_mon;

    jeff_74x157_scanner #(.WIDTH(4), .DWELL(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .stop(stop), .y(y),
        .s(s), .en(en), .a_data(a_data), .b_data(b_data), .pair_valid(pair_valid),
        .busy(busy), .scan_count(scan_count)
    );

    assign y = en ? (s ? b_in : a_in) : 4'h0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b, input int c);
        exp_t e;
        n = (n + 1) % 256;
        e.a = a;
        e.b = b;
        e.cnt = 8'(n);
        e.c = c;
        q.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go(output int kk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        kk = cyc;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    // monitor: every pair_valid must match the oldest expected pair, in its expected cycle
    always @(negedge clk) begin
        if (rst_n === 1'b1 && pair_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_pair_valid", 1, 0);
            end else begin
                e_mon = q.pop_front();
                chk("pair_a", a_data, e_mon.a);
                chk("pair_b", b_data, e_mon.b);
                chk("pair_count", scan_count, e_mon.cnt);
                chk("pair_cycle", cyc, e_mon.c);
            end
        end
    end

    initial begin
        #12;
        chk("rst_s", s, 0);
        chk("rst_en", en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pv", pair_valid, 0);
        chk("rst_a", a_data, 0);
        chk("rst_b", b_data, 0);
        chk("rst_count", scan_count, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        // single shot with select/enable timing
        a_in = 4'ha;
        b_in = 4'h5;
        go(k);
        push(4'ha, 4'h5, k + 8);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("single_s", s, i > 4);
            chk("single_en", en, 1);
            chk("single_busy", busy, 1);
        end
        @(negedge clk);
        chk("single_en_off", en, 0);
        chk("single_busy_off", busy, 0);
        @(posedge clk);
        #1;
        chk("single_count", scan_count, 1);
        // stop in idle does nothing; start in SEL_B is ignored (and its cont not sampled)
        pulse_stop();
        chk("idle_stop_busy", busy, 0);
        chk("idle_stop_en", en, 0);
        a_in = 4'hc;
        b_in = 4'h3;
        go(k);
        push(4'hc, 4'h3, k + 8);
        wait_to(k + 5);
        cont = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cont = 1'b0;
        wait_to(k + 10);
        chk("ignored_start_busy", busy, 0);
        chk("ignored_start_count", scan_count, 2);
        // continuous; inputs change during pair 2 SEL_B so pair 2 reads A=3, B=8
        a_in = 4'h3;
        b_in = 4'h7;
        cont = 1'b1;
        go(k);
        cont = 1'b0;
        push(4'h3, 4'h7, k + 8);
        push(4'h3, 4'h8, k + 16);
        push(4'h2, 4'h8, k + 24);
        push(4'h2, 4'h8, k + 32);
        wait_to(k + 13);
        a_in = 4'h2;
        b_in = 4'h8;
        wait_to(k + 26);
        pulse_stop();
        wait_to(k + 31);
        chk("cont_busy_before_end", busy, 1);
        wait_to(k + 34);
        chk("cont_busy_after_stop", busy, 0);
        chk("cont_count", scan_count, 6);
        // asynchronous reset in the middle of SEL_B
        a_in = 4'h6;
        b_in = 4'hf;
        go(k);
        wait_to(k + 6);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_en", en, 0);
        chk("midrst_s", s, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_pv", pair_valid, 0);
        chk("midrst_a", a_data, 0);
        chk("midrst_b", b_data, 0);
        chk("midrst_count", scan_count, 0);
        n = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        wait_to(cyc + 10);
        chk("midrst_idle", busy, 0);
        chk("midrst_b_kept", b_data, 0);
        // 256 continuous pairs: count wraps 255 -> 0
        a_in = 4'h9;
        b_in = 4'h4;
        cont = 1'b1;
        go(k);
        cont = 1'b0;
        for (int i = 1; i <= 256; i++) push(4'h9, 4'h4, k + 8 * i);
        wait_to(k + 8 * 255 + 2);
        pulse_stop();
        wait_to(k + 8 * 256 + 3);
        chk("wrap_busy", busy, 0);
        chk("wrap_count", scan_count, 0);
        wait_to(cyc + 4);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
